// File: rtl/prim_subreg_ext.sv
// Software/hardware register slice with selectable access mode and optional
// double-write shadowed update backed by an inverted storage copy.

package prim_subreg_pkg;
  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;
endpackage

module prim_subreg_ext
  import prim_subreg_pkg::*;
#(
  parameter int unsigned    DW       = 32,
  parameter sw_access_e     SwAccess = SwAccessRW,
  parameter logic [DW-1:0]  RESVAL   = '0,
  parameter bit             ShadowEn = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          qe,
  output logic [DW-1:0] qs,
  output logic          phase,
  output logic          err_update,
  output logic          err_storage
);

  if (DW < 1 || DW > 64) begin : g_bad_dw
    $error("prim_subreg_ext: DW must be in 1..64");
  end

  if (ShadowEn && !(SwAccess inside {SwAccessRW, SwAccessW1C, SwAccessW1S, SwAccessW0C}))
  begin : g_bad_shadow
    $error("prim_subreg_ext: shadowed update needs RW, W1C, W1S or W0C access");
  end

  typedef enum logic [0:0] {StIdle, StStaged} state_e;

  state_e        r_state;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_shadow;
  logic [DW-1:0] r_stage;
  logic          r_qe;
  logic          r_err_update;
  logic          r_err_storage;

  logic [DW-1:0] w_base;
  logic [DW-1:0] w_swv;
  logic          w_sw_wr;
  logic          w_rc_clr;
  logic          w_match;
  logic          w_q_en;
  logic [DW-1:0] w_q_nxt;
  logic          w_commit;

  // A same-cycle hardware write is the base for the bit-set/clear modes.
  assign w_base   = de ? d : r_q;
  assign w_sw_wr  = we && (SwAccess != SwAccessRO) && (SwAccess != SwAccessRC);
  assign w_rc_clr = re && (SwAccess == SwAccessRC);
  assign w_match  = (w_swv == r_stage);

  always_comb begin
    w_swv = wd;
    case (SwAccess)
      SwAccessW1C: w_swv = w_base & ~wd;
      SwAccessW1S: w_swv = w_base | wd;
      SwAccessW0C: w_swv = w_base & wd;
      default:     w_swv = wd;
    endcase
  end

  always_comb begin
    w_q_en   = 1'b0;
    w_q_nxt  = r_q;
    w_commit = 1'b0;
    if (ShadowEn) begin
      // A committing second write beats a concurrent hardware write.
      if (r_state == StStaged && we && w_match) begin
        w_q_en   = 1'b1;
        w_q_nxt  = r_stage;
        w_commit = 1'b1;
      end else if (de) begin
        w_q_en  = 1'b1;
        w_q_nxt = d;
      end
    end else begin
      if (w_sw_wr) begin
        w_q_en   = 1'b1;
        w_q_nxt  = w_swv;
        w_commit = 1'b1;
      end else if (de) begin
        w_q_en  = 1'b1;
        w_q_nxt = d;
      end else if (w_rc_clr) begin
        w_q_en  = 1'b1;
        w_q_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_q           <= RESVAL;
      r_shadow      <= ~RESVAL;
      r_stage       <= '0;
      r_qe          <= 1'b0;
      r_err_update  <= 1'b0;
      r_err_storage <= 1'b0;
    end else begin
      r_qe         <= w_commit;
      r_err_update <= 1'b0;
      if (w_q_en) begin
        r_q      <= w_q_nxt;
        r_shadow <= ~w_q_nxt;
      end
      if (ShadowEn) begin
        r_err_storage <= r_err_storage | (r_q != ~r_shadow);
        unique case (r_state)
          StIdle: begin
            if (we) begin
              r_stage <= w_swv;
              r_state <= StStaged;
            end
          end
          StStaged: begin
            if (we) begin
              r_err_update <= ~w_match;
              r_stage      <= '0;
              r_state      <= StIdle;
            end else if (re) begin
              r_stage <= '0;
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign q           = r_q;
  assign qe          = r_qe;
  assign qs          = (SwAccess == SwAccessWO) ? '0 : r_q;
  assign phase       = ShadowEn && (r_state == StStaged);
  assign err_update  = ShadowEn && r_err_update;
  assign err_storage = ShadowEn && r_err_storage;

endmodule

// File: tb/tb_prim_subreg_ext.sv
// Scoreboard bench: stimulus queues expected outputs per instance, a negedge
// monitor pops and compares against four differently configured instances.

module tb_prim_subreg_ext;
  import prim_subreg_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] q;
    logic [31:0] qs;
    logic        qe;
    logic        ph;
    logic        eu;
    logic        es;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t sb_w1c[$];
  exp_t sb_rc[$];
  exp_t sb_sh[$];
  exp_t sb_wo[$];

  logic        w1c_we, w1c_re, w1c_de, w1c_qe, w1c_ph, w1c_eu, w1c_es;
  logic [7:0]  w1c_wd, w1c_d, w1c_q, w1c_qs;
  logic        rc_we, rc_re, rc_de, rc_qe, rc_ph, rc_eu, rc_es;
  logic [15:0] rc_wd, rc_d, rc_q, rc_qs;
  logic        sh_we, sh_re, sh_de, sh_qe, sh_ph, sh_eu, sh_es;
  logic [31:0] sh_wd, sh_d, sh_q, sh_qs;
  logic        wo_we, wo_re, wo_de, wo_qe, wo_ph, wo_eu, wo_es;
  logic [7:0]  wo_wd, wo_d, wo_q, wo_qs;

  prim_subreg_ext #(.DW(8), .SwAccess(SwAccessW1C), .RESVAL(8'hFF), .ShadowEn(1'b0)) u_w1c (
    .clk_i(clk), .rst_i(rst), .we(w1c_we), .wd(w1c_wd), .re(w1c_re), .de(w1c_de), .d(w1c_d),
    .q(w1c_q), .qe(w1c_qe), .qs(w1c_qs), .phase(w1c_ph), .err_update(w1c_eu),
    .err_storage(w1c_es)
  );

  prim_subreg_ext #(.DW(16), .SwAccess(SwAccessRC), .RESVAL(16'h0000), .ShadowEn(1'b0)) u_rc (
    .clk_i(clk), .rst_i(rst), .we(rc_we), .wd(rc_wd), .re(rc_re), .de(rc_de), .d(rc_d),
    .q(rc_q), .qe(rc_qe), .qs(rc_qs), .phase(rc_ph), .err_update(rc_eu), .err_storage(rc_es)
  );

  prim_subreg_ext #(.DW(32), .SwAccess(SwAccessRW), .RESVAL(32'hDEADBEEF), .ShadowEn(1'b1)) u_sh (
    .clk_i(clk), .rst_i(rst), .we(sh_we), .wd(sh_wd), .re(sh_re), .de(sh_de), .d(sh_d),
    .q(sh_q), .qe(sh_qe), .qs(sh_qs), .phase(sh_ph), .err_update(sh_eu), .err_storage(sh_es)
  );

  prim_subreg_ext #(.DW(8), .SwAccess(SwAccessWO), .RESVAL(8'h00), .ShadowEn(1'b0)) u_wo (
    .clk_i(clk), .rst_i(rst), .we(wo_we), .wd(wo_wd), .re(wo_re), .de(wo_de), .d(wo_d),
    .q(wo_q), .qe(wo_qe), .qs(wo_qs), .phase(wo_ph), .err_update(wo_eu), .err_storage(wo_es)
  );

  function automatic exp_t mk(input string nm, input logic [31:0] q_v, input logic [31:0] qs_v,
                              input logic qe_v, input logic ph_v, input logic eu_v,
                              input logic es_v);
    exp_t e;
    e.nm = nm; e.q = q_v; e.qs = qs_v; e.qe = qe_v; e.ph = ph_v; e.eu = eu_v; e.es = es_v;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [31:0] aq, input logic [31:0] aqs,
                     input logic aqe, input logic aph, input logic aeu, input logic aes);
    chk({e.nm, ".q"}, aq, e.q);
    chk({e.nm, ".qs"}, aqs, e.qs);
    chk({e.nm, ".qe"}, 32'(aqe), 32'(e.qe));
    chk({e.nm, ".phase"}, 32'(aph), 32'(e.ph));
    chk({e.nm, ".err_update"}, 32'(aeu), 32'(e.eu));
    chk({e.nm, ".err_storage"}, 32'(aes), 32'(e.es));
  endtask

  // Outputs are registered; sampling on the falling edge keeps clear of updates.
  always @(negedge clk) begin
    exp_t e;
    if (sb_w1c.size() != 0) begin
      e = sb_w1c.pop_front();
      cmp(e, 32'(w1c_q), 32'(w1c_qs), w1c_qe, w1c_ph, w1c_eu, w1c_es);
    end
    if (sb_rc.size() != 0) begin
      e = sb_rc.pop_front();
      cmp(e, 32'(rc_q), 32'(rc_qs), rc_qe, rc_ph, rc_eu, rc_es);
    end
    if (sb_sh.size() != 0) begin
      e = sb_sh.pop_front();
      cmp(e, sh_q, sh_qs, sh_qe, sh_ph, sh_eu, sh_es);
    end
    if (sb_wo.size() != 0) begin
      e = sb_wo.pop_front();
      cmp(e, 32'(wo_q), 32'(wo_qs), wo_qe, wo_ph, wo_eu, wo_es);
    end
  end

  task automatic clr_in();
    w1c_we = 0; w1c_re = 0; w1c_de = 0; w1c_wd = '0; w1c_d = '0;
    rc_we  = 0; rc_re  = 0; rc_de  = 0; rc_wd  = '0; rc_d  = '0;
    sh_we  = 0; sh_re  = 0; sh_de  = 0; sh_wd  = '0; sh_d  = '0;
    wo_we  = 0; wo_re  = 0; wo_de  = 0; wo_wd  = '0; wo_d  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb_w1c.push_back(mk("w1c_rst", 32'hFF, 32'hFF, 0, 0, 0, 0));
    sb_rc.push_back(mk("rc_rst", 32'h0, 32'h0, 0, 0, 0, 0));
    sb_sh.push_back(mk("sh_rst", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
    sb_wo.push_back(mk("wo_rst", 32'h0, 32'h0, 0, 0, 0, 0));

    // W1C: FF & ~0F = F0; then base is d=33, 33 & ~03 = 30.
    w1c_we = 1; w1c_wd = 8'h0F; tick();
    sb_w1c.push_back(mk("w1c_clr", 32'hF0, 32'hF0, 1, 0, 0, 0));
    clr_in(); tick();
    sb_w1c.push_back(mk("w1c_qe_drop", 32'hF0, 32'hF0, 0, 0, 0, 0));
    w1c_de = 1; w1c_d = 8'h33; w1c_we = 1; w1c_wd = 8'h03; tick();
    sb_w1c.push_back(mk("w1c_hw_base", 32'h30, 32'h30, 1, 0, 0, 0));
    clr_in(); w1c_de = 1; w1c_d = 8'hAA; tick();
    sb_w1c.push_back(mk("w1c_hw_only", 32'hAA, 32'hAA, 0, 0, 0, 0));
    clr_in();

    // RC: hardware load, read clear, hardware wins over clear, writes ignored.
    rc_de = 1; rc_d = 16'hABCD; tick();
    sb_rc.push_back(mk("rc_load", 32'hABCD, 32'hABCD, 0, 0, 0, 0));
    clr_in(); rc_re = 1; tick();
    sb_rc.push_back(mk("rc_clear", 32'h0, 32'h0, 0, 0, 0, 0));
    clr_in(); rc_de = 1; rc_d = 16'hABCD; tick();
    sb_rc.push_back(mk("rc_reload", 32'hABCD, 32'hABCD, 0, 0, 0, 0));
    rc_re = 1; rc_d = 16'h1234; tick();
    sb_rc.push_back(mk("rc_hw_wins", 32'h1234, 32'h1234, 0, 0, 0, 0));
    clr_in(); rc_we = 1; rc_wd = 16'hFFFF; tick();
    sb_rc.push_back(mk("rc_we_ign", 32'h1234, 32'h1234, 0, 0, 0, 0));
    clr_in();

    // WO: q takes the write, readback stays zero.
    wo_we = 1; wo_wd = 8'h5C; tick();
    sb_wo.push_back(mk("wo_write", 32'h5C, 32'h0, 1, 0, 0, 0));
    clr_in(); tick();
    sb_wo.push_back(mk("wo_hold", 32'h5C, 32'h0, 0, 0, 0, 0));

    // Shadow: matching double write commits.
    sh_we = 1; sh_wd = 32'h5A5A5A5A; tick();
    sb_sh.push_back(mk("sh_stage", 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 0, 0));
    tick();
    sb_sh.push_back(mk("sh_commit", 32'h5A5A5A5A, 32'h5A5A5A5A, 1, 0, 0, 0));
    clr_in(); tick();
    sb_sh.push_back(mk("sh_idle", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 0, 0, 0));

    // Mismatching second write.
    sh_we = 1; sh_wd = 32'h1; tick();
    sb_sh.push_back(mk("sh_mis_stage", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 1, 0, 0));
    sh_wd = 32'h2; tick();
    sb_sh.push_back(mk("sh_mismatch", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 0, 1, 0));
    clr_in(); tick();
    sb_sh.push_back(mk("sh_mis_drop", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 0, 0, 0));

    // Read aborts a staged write; the next write is a fresh first phase.
    sh_we = 1; sh_wd = 32'h7; tick();
    sb_sh.push_back(mk("sh_ab_stage", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 1, 0, 0));
    clr_in(); sh_re = 1; tick();
    sb_sh.push_back(mk("sh_abort", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 0, 0, 0));
    clr_in(); sh_we = 1; sh_wd = 32'h9; tick();
    sb_sh.push_back(mk("sh_ab_restage", 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 1, 0, 0));
    tick();
    sb_sh.push_back(mk("sh_ab_commit", 32'h9, 32'h9, 1, 0, 0, 0));

    // Reset while staged.
    sh_wd = 32'h3; tick();
    sb_sh.push_back(mk("sh_rs_stage", 32'h9, 32'h9, 0, 1, 0, 0));
    clr_in(); rst = 1; tick();
    sb_sh.push_back(mk("sh_mid_rst", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
    rst = 0; sh_we = 1; sh_wd = 32'h3; tick();
    sb_sh.push_back(mk("sh_rs_first", 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 0, 0));
    tick();
    sb_sh.push_back(mk("sh_rs_commit", 32'h3, 32'h3, 1, 0, 0, 0));

    // Hardware write keeps the shadow copy consistent.
    clr_in(); sh_de = 1; sh_d = 32'hCAFEF00D; tick();
    sb_sh.push_back(mk("sh_hw", 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0));
    clr_in(); tick();
    sb_sh.push_back(mk("sh_hw_cons", 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0));

    // Commit and hardware write together: software value wins.
    sh_we = 1; sh_wd = 32'h11111111; tick();
    sb_sh.push_back(mk("sh_sw_stage", 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 0, 0));
    sh_de = 1; sh_d = 32'h22222222; tick();
    sb_sh.push_back(mk("sh_sw_wins", 32'h11111111, 32'h11111111, 1, 0, 0, 0));
    clr_in(); tick();
    sb_sh.push_back(mk("sh_sw_cons", 32'h11111111, 32'h11111111, 0, 0, 0, 0));

    // Corrupt bit 0 of the inverted copy (~11111111 = EEEEEEEE).
    force u_sh.r_shadow = 32'hEEEEEEEF;
    tick();
    sb_sh.push_back(mk("sh_es_set", 32'h11111111, 32'h11111111, 0, 0, 0, 1));
    release u_sh.r_shadow;
    tick();
    sb_sh.push_back(mk("sh_es_hold", 32'h11111111, 32'h11111111, 0, 0, 0, 1));
    sh_de = 1; sh_d = 32'h44444444; tick();
    sb_sh.push_back(mk("sh_es_sticky", 32'h44444444, 32'h44444444, 0, 0, 0, 1));
    clr_in(); rst = 1; tick();
    sb_sh.push_back(mk("sh_es_rst", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
    rst = 0; tick();
    sb_sh.push_back(mk("sh_es_clean", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));

    for (int i = 0; i < 10; i++) begin
      if (sb_w1c.size() + sb_rc.size() + sb_sh.size() + sb_wo.size() == 0) break;
      tick();
    end
    checks++;
    if (sb_w1c.size() + sb_rc.size() + sb_sh.size() + sb_wo.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sb_w1c.size() + sb_rc.size() + sb_sh.size() + sb_wo.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
